// File: rtl/card_shoe_pkg.sv
// Shared constants and helpers for the card shoe: deck geometry, FSM encoding, LFSR taps.
package card_shoe_pkg;

    typedef logic [3:0] card_t;

    localparam int unsigned DECK_SIZE = 52;
    localparam logic [5:0]  DECK_LAST = 6'd51;
    localparam logic [5:0]  DECK_FULL = 6'd52;

    localparam logic [1:0] FILL    = 2'd0;
    localparam logic [1:0] SHUFFLE = 2'd1;
    localparam logic [1:0] READY   = 2'd2;

    // x^16 + x^14 + x^13 + x^11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam card_t CARD_MAX = 4'd10;
    localparam card_t RANK_MAX = 4'd13;

    // Face cards count as ten.
    function automatic card_t card_of_rank(input card_t rank);
        return (rank > CARD_MAX) ? CARD_MAX : rank;
    endfunction

endpackage

// File: rtl/card_shoe_lfsr16.sv
// 16-bit Fibonacci LFSR; a zero seed is forced to 1 so the register can never lock up.
module lfsr16
    import card_shoe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] state_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else begin
            state_q <= {state_q[14:0], ^(state_q & LFSR_TAPS)};
        end
    end

    assign state = state_q;

endmodule

// File: rtl/card_shoe.sv
// 52-card shoe: fills a deck, Fisher-Yates shuffles it from an LFSR, then deals one card per request.
module card_shoe
    import card_shoe_pkg::*;
#(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned LOW_WATER = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shuffle_req,
    input  logic       deal_req,
    output logic       card_valid,
    output logic [3:0] card_val,
    output logic       ready,
    output logic       low,
    output logic [5:0] cards_left
);

    localparam logic [5:0] LOW_WATER_W = 6'(LOW_WATER);

    logic [15:0] lfsr;
    logic        lfsr_unused;
    logic [5:0]  r;

    logic [1:0] state_q, state_d;
    logic [5:0] k_q, k_d;
    logic [5:0] i_q, i_d;
    logic [5:0] ptr_q, ptr_d;
    card_t      rank_q, rank_d;
    logic [5:0] cards_left_q, cards_left_d;
    logic       ready_q, ready_d;
    logic       low_q, low_d;
    logic       card_valid_q, card_valid_d;
    card_t      card_val_q, card_val_d;

    logic       fill_we;
    logic       swap_en;
    card_t      deck [DECK_SIZE];

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .seed  (SEED),
        .state (lfsr)
    );

    assign r           = lfsr[5:0];
    assign lfsr_unused = ^lfsr[15:6];

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        i_d          = i_q;
        ptr_d        = ptr_q;
        rank_d       = rank_q;
        cards_left_d = cards_left_q;
        ready_d      = ready_q;
        card_valid_d = 1'b0;
        card_val_d   = card_val_q;
        fill_we      = 1'b0;
        swap_en      = 1'b0;

        unique case (state_q)
            FILL: begin
                fill_we = 1'b1;
                k_d     = k_q + 6'd1;
                rank_d  = (rank_q == RANK_MAX) ? 4'd1 : rank_q + 4'd1;
                if (k_q == DECK_LAST) begin
                    k_d     = 6'd0;
                    i_d     = DECK_LAST;
                    state_d = SHUFFLE;
                end
            end
            SHUFFLE: begin
                // Draws above i are rejected rather than reduced, keeping the shuffle unbiased.
                if (r <= i_q) begin
                    swap_en = 1'b1;
                    i_d     = i_q - 6'd1;
                    if (i_q == 6'd1) begin
                        state_d      = READY;
                        ptr_d        = 6'd0;
                        cards_left_d = DECK_FULL;
                        ready_d      = 1'b1;
                    end
                end
            end
            READY: begin
                if (shuffle_req) begin
                    state_d      = FILL;
                    k_d          = 6'd0;
                    rank_d       = 4'd1;
                    ready_d      = 1'b0;
                    cards_left_d = 6'd0;
                end else if (deal_req && (cards_left_q != 6'd0)) begin
                    card_valid_d = 1'b1;
                    card_val_d   = deck[ptr_q];
                    ptr_d        = ptr_q + 6'd1;
                    cards_left_d = cards_left_q - 6'd1;
                end
            end
            default: begin
                state_d = FILL;
                k_d     = 6'd0;
                rank_d  = 4'd1;
            end
        endcase

        low_d = ready_d && (cards_left_d < LOW_WATER_W);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= FILL;
            k_q          <= 6'd0;
            i_q          <= 6'd0;
            ptr_q        <= 6'd0;
            rank_q       <= 4'd1;
            cards_left_q <= 6'd0;
            ready_q      <= 1'b0;
            low_q        <= 1'b0;
            card_valid_q <= 1'b0;
            card_val_q   <= 4'd0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            i_q          <= i_d;
            ptr_q        <= ptr_d;
            rank_q       <= rank_d;
            cards_left_q <= cards_left_d;
            ready_q      <= ready_d;
            low_q        <= low_d;
            card_valid_q <= card_valid_d;
            card_val_q   <= card_val_d;
        end
    end

    // Deck contents need no reset: FILL rewrites every slot before it is read.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (fill_we) begin
                deck[k_q] <= card_of_rank(rank_q);
            end else if (swap_en) begin
                deck[i_q] <= deck[r];
                deck[r]   <= deck[i_q];
            end
        end
    end

    assign card_valid = card_valid_q;
    assign card_val   = card_val_q;
    assign ready      = ready_q;
    assign low        = low_q;
    assign cards_left = cards_left_q;

endmodule

// File: doc/card_shoe.md
Name: card_shoe

Overview:
- Upstream card source for the blackjack game controller.
- Replaces free-running pseudo-random value generation with a real 52-card deck, so card frequencies match a physical deck.
- Fills the deck, shuffles it with a Fisher-Yates pass driven by an LFSR, then deals one card value (1..10, ace = 1) per request.
- The game controller stays responsible for ace-as-11 handling, hand sums and the 7-segment display.

Parameters:
- SEED, 16'hACE1, initial LFSR state. A value of 0 is replaced by 16'h0001 at reset.
- LOW_WATER, 15, when cards_left is below this value, `low` is asserted.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  synchronous reset, active-low
- shuffle_req  in  1  request a refill and reshuffle; sampled only in READY
- deal_req  in  1  request one card; level-sensitive, one card per cycle while held
- card_valid  out  1  one-cycle strobe; card_val is valid this cycle
- card_val  out  4  card value, 1..10
- ready  out  1  deck shuffled and dealing enabled
- low  out  1  cards_left < LOW_WATER (only meaningful while ready)
- cards_left  out  6  undealt cards, 0..52

Behaviour:
- Reset (rst == 0 at a clock edge):
  - state <= FILL; k, i, ptr <= 0.
  - lfsr <= SEED, or 16'h0001 if SEED is 0.
  - card_valid, card_val, ready, cards_left <= 0; low <= 0.
  - Reset mid-FILL, mid-SHUFFLE or mid-deal discards all progress.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11.
  - Advances every cycle rst == 1, in every state.
- FILL:
  - One write per cycle, k = 0..51: deck[k] <= min(rank, 10).
  - rank is a counter running 1..13 and wrapping to 1.
  - After k == 51: i <= 51, state <= SHUFFLE. FILL takes exactly 52 cycles.
- SHUFFLE:
  - Each cycle, r = lfsr[5:0].
  - If r <= i: swap deck[i] and deck[r] (r == i is a legal no-op swap), then i <= i-1.
  - Otherwise retry next cycle with no change.
  - When the swap for i == 1 completes: state <= READY, ptr <= 0, cards_left <= 52, ready <= 1.
- READY, priority order:
  1. shuffle_req == 1: state <= FILL, ready <= 0, cards_left <= 0, no card dealt even if deal_req == 1.
  2. deal_req == 1 and cards_left != 0: next cycle card_valid = 1 and card_val = deck[ptr]; ptr <= ptr+1; cards_left <= cards_left-1. Latency is 1 cycle and throughput is 1 card per cycle.
  3. deal_req == 1 and cards_left == 0: ignored, card_valid stays 0, no wrap-around of ptr. The deck stays empty until shuffle_req.
- Requests outside READY:
  - deal_req and shuffle_req are ignored in FILL and SHUFFLE.
- Output register behaviour:
  - card_valid is 0 on every cycle without a deal.
  - card_val holds its last value when card_valid is 0.
  - All outputs are registered.
- Invariant: the 52 cards dealt per shuffle contain four each of 1..9 and sixteen 10s, summing to 340.

Decomposition:
- Shared package holds:
  - DECK_SIZE = 52
  - state encoding: FILL = 2'd0, SHUFFLE = 2'd1, READY = 2'd2
  - LFSR tap mask 16'hB400
  - max card value 10
- One sub-module is natural: lfsr16 (clk, rst, seed, state output).
- The deck array, swap logic and deal logic stay in card_shoe.

Test Plan:
- Reset, then hold deal_req = 0 → ready rises after ≥103 cycles and within 2000 cycles; cards_left == 52; card_valid is never 1 before ready.
- Hold deal_req = 1 for 60 cycles after ready → exactly 52 card_valid strobes on consecutive cycles; value histogram is 1..9 ×4 and 10 ×16, sum 340; cards_left reaches 0, then no further strobes.
- Single-cycle deal_req pulse with cards_left == 52 → card_valid for exactly one cycle, on the next cycle; cards_left == 51; low goes high when cards_left == 14.
- shuffle_req and deal_req both 1 with cards_left == 30 → no card_valid; ready falls next cycle and cards_left == 0; ready rises again with cards_left == 52.
- rst = 0 for one cycle midway through SHUFFLE → outputs cleared; full FILL+SHUFFLE reruns; with the same SEED, the deal sequence is bit-identical to the post-reset sequence.
- Two resets, one with SEED = 16'hACE1 and one with SEED = 0 → different deal orders; the SEED = 0 run behaves as seed 16'h0001 and never locks up (LFSR never 0).
